// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle control FSM with memory handshakes, traps and an instret counter
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_alu_zero,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_ir_write,
    output logic             o_dmem_read,
    output logic             o_dmem_write,
    output logic             o_alu_src,
    output logic [1:0]       o_alu_op,
    output logic             o_reg_write,
    output logic [1:0]       o_wb_sel,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic             o_trap,
    output logic [CNT_W-1:0] o_instret
);
    localparam int WW = $clog2(TIMEOUT + 2);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    state_t          r_state;
    logic [WW-1:0]   r_wait;
    logic [CNT_W-1:0] r_instret;

    logic w_op, w_opimm, w_load, w_store, w_branch, w_jal, w_jalr, w_lui, w_auipc;
    logic w_legal, w_taken, w_ready, w_waiting, w_timeout;

    assign w_op      = i_opcode == OP_R;
    assign w_opimm   = i_opcode == OP_I;
    assign w_load    = i_opcode == OP_LD;
    assign w_store   = i_opcode == OP_ST;
    assign w_branch  = i_opcode == OP_BR;
    assign w_jal     = i_opcode == OP_JAL;
    assign w_jalr    = i_opcode == OP_JALR;
    assign w_lui     = i_opcode == OP_LUI;
    assign w_auipc   = i_opcode == OP_AUIPC;
    assign w_legal   = w_op | w_opimm | w_load | w_store | w_jal | w_jalr | w_lui | w_auipc |
                       (w_branch & (i_funct3[2:1] != 2'b01));
    // ALU does sub/slt/sltu, so taken is zero for beq/bge/bgeu and !zero for bne/blt/bltu
    assign w_taken   = i_alu_zero ^ i_funct3[0] ^ i_funct3[2];
    assign w_ready   = r_state == S_FETCH ? i_imem_ready : i_dmem_ready;
    assign w_waiting = (r_state == S_FETCH || r_state == S_MEM) && !w_ready;
    assign w_timeout = TIMEOUT != 0 && w_waiting && r_wait == WW'(TIMEOUT - 1);
    assign o_instret = rst ? '0 : r_instret;

    always_comb begin
        o_imem_req   = 1'b0;
        o_ir_write   = 1'b0;
        o_dmem_read  = 1'b0;
        o_dmem_write = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 2'b00;
        o_reg_write  = 1'b0;
        o_wb_sel     = 2'b00;
        o_pc_write   = 1'b0;
        o_pc_src     = 2'b00;
        o_trap       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_write = i_imem_ready;
                end
                S_EXEC: begin
                    o_alu_src   = w_opimm | w_lui | w_auipc | w_load | w_store | w_jalr;
                    o_alu_op    = (w_op | w_opimm) ? 2'b10 : (w_lui | w_auipc) ? 2'b11 :
                                  w_branch ? 2'b01 : 2'b00;
                    o_reg_write = w_jal | w_jalr;
                    o_wb_sel    = {w_jal | w_jalr, 1'b0};
                    o_pc_write  = w_branch | w_jal | w_jalr;
                    o_pc_src    = w_jalr ? 2'b10 : (w_jal | (w_branch & w_taken)) ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    o_alu_src    = 1'b1;
                    o_dmem_read  = w_load;
                    o_dmem_write = w_store;
                    o_pc_write   = w_store & i_dmem_ready;
                end
                S_WB: begin
                    o_reg_write = 1'b1;
                    o_wb_sel    = {1'b0, w_load};
                    o_pc_write  = 1'b1;
                end
                S_TRAP:  o_trap = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            if (o_pc_write) r_instret <= r_instret + 1'b1;
            // any non-waiting cycle clears the count, so FETCH/MEM are always entered at zero
            r_wait <= w_waiting ? r_wait + 1'b1 : '0;
            case (r_state)
                S_FETCH:  r_state <= w_timeout ? S_TRAP : i_imem_ready ? S_DECODE : S_FETCH;
                S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
                S_EXEC:   r_state <= (w_load | w_store) ? S_MEM :
                                     (w_branch | w_jal | w_jalr) ? S_FETCH : S_WB;
                S_MEM:    r_state <= w_timeout ? S_TRAP : !i_dmem_ready ? S_MEM :
                                     w_load ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                default:  r_state <= S_TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle strobe checks plus wait/timeout/trap/reset sequences
module tb_multicycle_control;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] op = 7'h0;
    logic [2:0] f3 = 3'h0;
    logic       z = 1'b0, imem = 1'b1, dmem = 1'b1;
    logic       imem_req, ir_write, dmem_read, dmem_write, alu_src, reg_write, pc_write, trap;
    logic [1:0] alu_op, wb_sel, pc_src;
    logic [3:0] instret;
    logic [13:0] w_out;
    int errors = 0, checks = 0;
    logic [3:0] cnt = 4'd0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_opcode(op), .i_funct3(f3), .i_alu_zero(z),
        .i_imem_ready(imem), .i_dmem_ready(dmem), .o_imem_req(imem_req), .o_ir_write(ir_write),
        .o_dmem_read(dmem_read), .o_dmem_write(dmem_write), .o_alu_src(alu_src), .o_alu_op(alu_op),
        .o_reg_write(reg_write), .o_wb_sel(wb_sel), .o_pc_write(pc_write), .o_pc_src(pc_src),
        .o_trap(trap), .o_instret(instret)
    );

    assign w_out = {imem_req, ir_write, dmem_read, dmem_write, alu_src, alu_op,
                    reg_write, wb_sel, pc_write, pc_src, trap};

    typedef struct {
        string          nm;
        logic [6:0]     op;
        logic [2:0]     f3;
        logic           z;
        int             n;
        logic [4:0][13:0] e;
    } vec_t;

    function automatic logic [13:0] sg(input int im, irw, dr, dw, as, aop, rw, wb, pw, ps, tr);
        return {im[0], irw[0], dr[0], dw[0], as[0], aop[1:0], rw[0], wb[1:0], pw[0], ps[1:0], tr[0]};
    endfunction

    logic [13:0] F, T, WB, LS_E, LW_M, LW_W, SW_M, BT, BN, JAL, JALR, WAITF, SW_WAIT;

    function automatic vec_t mk(input string nm, input logic [6:0] o, input logic [2:0] f,
                                input logic zz, input int n, input logic [13:0] x, y, w);
        vec_t v;
        v.nm = nm; v.op = o; v.f3 = f; v.z = zz; v.n = n;
        v.e[0] = F; v.e[1] = 14'h0; v.e[2] = x; v.e[3] = y; v.e[4] = w;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; imem = 1'b1; dmem = 1'b1;
        #1;
        chk("reset outputs", 32'(w_out), 32'h0);
        chk("reset instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 4'd0;
    endtask

    task automatic run(input vec_t v);
        for (int c = 0; c < v.n; c++) begin
            step();
            op = v.op; f3 = v.f3; z = v.z; imem = 1'b1; dmem = 1'b1;
            #1;
            chk($sformatf("%s cyc%0d", v.nm, c), 32'(w_out), 32'(v.e[c]));
        end
        cnt++;
        @(posedge clk);
        #1;
        chk($sformatf("%s instret", v.nm), 32'(instret), 32'(cnt));
    endtask

    task automatic cyc(input string nm, input logic [13:0] e);
        step();
        #1;
        chk(nm, 32'(w_out), 32'(e));
    endtask

    vec_t tbl[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int rd, nc;
        F       = sg(1,1,0,0,0,0,0,0,0,0,0);
        T       = sg(0,0,0,0,0,0,0,0,0,0,1);
        WB      = sg(0,0,0,0,0,0,1,0,1,0,0);
        LS_E    = sg(0,0,0,0,1,0,0,0,0,0,0);
        LW_M    = sg(0,0,1,0,1,0,0,0,0,0,0);
        LW_W    = sg(0,0,0,0,0,0,1,1,1,0,0);
        SW_M    = sg(0,0,0,1,1,0,0,0,1,0,0);
        SW_WAIT = sg(0,0,0,1,1,0,0,0,0,0,0);
        BT      = sg(0,0,0,0,0,1,0,0,1,1,0);
        BN      = sg(0,0,0,0,0,1,0,0,1,0,0);
        JAL     = sg(0,0,0,0,0,0,1,2,1,1,0);
        JALR    = sg(0,0,0,0,1,0,1,2,1,2,0);
        WAITF   = sg(1,0,0,0,0,0,0,0,0,0,0);
        tbl[0]  = mk("addi",  7'b0010011, 3'b000, 1'b0, 4, sg(0,0,0,0,1,2,0,0,0,0,0), WB, 14'h0);
        tbl[1]  = mk("add",   7'b0110011, 3'b000, 1'b0, 4, sg(0,0,0,0,0,2,0,0,0,0,0), WB, 14'h0);
        tbl[2]  = mk("lui",   7'b0110111, 3'b000, 1'b0, 4, sg(0,0,0,0,1,3,0,0,0,0,0), WB, 14'h0);
        tbl[3]  = mk("auipc", 7'b0010111, 3'b000, 1'b0, 4, sg(0,0,0,0,1,3,0,0,0,0,0), WB, 14'h0);
        tbl[4]  = mk("lw",    7'b0000011, 3'b010, 1'b0, 5, LS_E, LW_M, LW_W);
        tbl[5]  = mk("sw",    7'b0100011, 3'b010, 1'b0, 4, LS_E, SW_M, 14'h0);
        tbl[6]  = mk("beq_t", 7'b1100011, 3'b000, 1'b1, 3, BT, 14'h0, 14'h0);
        tbl[7]  = mk("beq_n", 7'b1100011, 3'b000, 1'b0, 3, BN, 14'h0, 14'h0);
        tbl[8]  = mk("bne_t", 7'b1100011, 3'b001, 1'b0, 3, BT, 14'h0, 14'h0);
        tbl[9]  = mk("bne_n", 7'b1100011, 3'b001, 1'b1, 3, BN, 14'h0, 14'h0);
        tbl[10] = mk("blt_t", 7'b1100011, 3'b100, 1'b0, 3, BT, 14'h0, 14'h0);
        tbl[11] = mk("bge_t", 7'b1100011, 3'b101, 1'b1, 3, BT, 14'h0, 14'h0);
        tbl[12] = mk("bltu_n",7'b1100011, 3'b110, 1'b1, 3, BN, 14'h0, 14'h0);
        tbl[13] = mk("bgeu_n",7'b1100011, 3'b111, 1'b0, 3, BN, 14'h0, 14'h0);
        tbl[14] = mk("jal",   7'b1101111, 3'b000, 1'b0, 3, JAL, 14'h0, 14'h0);
        tbl[15] = mk("jalr",  7'b1100111, 3'b000, 1'b0, 3, JALR, 14'h0, 14'h0);

        do_reset();
        // 16 retires from reset also exercise the 4-bit instret wrap to 0
        foreach (tbl[i]) run(tbl[i]);

        // load with 3 dmem wait cycles
        op = 7'b0000011; rd = 0; nc = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            imem = 1'b1; dmem = rd >= 3;
            #1;
            nc++;
            if (dmem_read) rd++;
            if (reg_write) chk("lw wait wb_sel", 32'(wb_sel), 32'd1);
            if (pc_write) break;
        end
        chk("lw wait cycles", nc, 8);
        chk("lw wait dmem_read cycles", rd, 4);
        cnt++;
        @(posedge clk);
        #1;
        chk("lw wait instret", 32'(instret), 32'(cnt));

        // illegal opcode
        op = 7'b1111111;
        cyc("ill F", F);
        cyc("ill D", 14'h0);
        for (int c = 0; c < 3; c++) cyc($sformatf("ill trap%0d", c), T);
        chk("ill instret frozen", 32'(instret), 32'(cnt));
        do_reset();

        // BRANCH with reserved funct3 010
        op = 7'b1100011; f3 = 3'b010; z = 1'b1;
        cyc("br010 F", F);
        cyc("br010 D", 14'h0);
        cyc("br010 trap0", T);
        cyc("br010 trap1", T);
        do_reset();

        // fetch timeout after 4 wait cycles
        op = 7'b0010011; f3 = 3'b000;
        step(); imem = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            #1;
            chk($sformatf("ifto wait%0d", c), 32'(w_out), 32'(WAITF));
        end
        cyc("ifto trap", T);
        do_reset();

        // imem_ready on the 4th wait cycle is a success
        step(); imem = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            chk($sformatf("ifok wait%0d", c), 32'(w_out), 32'(WAITF));
        end
        step(); imem = 1'b1;
        #1;
        chk("ifok F", 32'(w_out), 32'(F));
        cyc("ifok D", 14'h0);
        cyc("ifok E", sg(0,0,0,0,1,2,0,0,0,0,0));
        cyc("ifok W", WB);
        cnt++;

        // store data timeout
        op = 7'b0100011;
        cyc("swto F", F);
        cyc("swto D", 14'h0);
        step(); dmem = 1'b0;
        #1;
        chk("swto E", 32'(w_out), 32'(LS_E));
        for (int c = 0; c < 4; c++) cyc($sformatf("swto wait%0d", c), SW_WAIT);
        cyc("swto trap", T);
        do_reset();

        // reset mid-MEM on a store drops the request and clears instret
        run(tbl[14]);
        op = 7'b0100011;
        cyc("swrst F", F);
        cyc("swrst D", 14'h0);
        step(); dmem = 1'b0;
        #1;
        chk("swrst E", 32'(w_out), 32'(LS_E));
        cyc("swrst M", SW_WAIT);
        step(); rst = 1'b1; dmem = 1'b1;
        #1;
        chk("swrst rst outputs", 32'(w_out), 32'h0);
        chk("swrst rst instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("swrst F after", F);
        chk("swrst instret after", 32'(instret), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
